// File: rtl/call_stack_ctrl_pkg.sv
// Shared definitions for the return-address call stack: FSM encoding and
// default geometry.
package call_stack_ctrl_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        ERR  = 1'b1
    } state_t;

    localparam int DEFAULT_DEPTH = 8;
    localparam int DEFAULT_AW    = 10;

endpackage : call_stack_ctrl_pkg

// File: rtl/call_stack_ctrl_lifo_mem.sv
// Return-address storage: synchronous write, combinational read, no reset
// (contents are meaningless until written).
module lifo_mem #(
    parameter int DEPTH = 8,
    parameter int AW    = 10,
    parameter int IW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [IW-1:0] i_waddr,
    input  logic [AW-1:0] i_wdata,
    input  logic [IW-1:0] i_raddr,
    output logic [AW-1:0] o_rdata
);

    logic [AW-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule : lifo_mem

// File: rtl/call_stack_ctrl.sv
// Call/return stack controller: push/pop/swap of return addresses with sticky
// overflow/underflow errors that freeze the stack until err_clr.
module call_stack_ctrl
    import call_stack_ctrl_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int AW    = DEFAULT_AW,
    parameter int DW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          call_req,
    input  logic          ret_req,
    input  logic [AW-1:0] push_addr,
    input  logic          err_clr,
    output logic [AW-1:0] ret_addr,
    output logic          ret_valid,
    output logic [DW-1:0] depth,
    output logic          full,
    output logic          empty,
    output logic          ovf_err,
    output logic          unf_err,
    output state_t        dbg_state
);

    localparam int IW = $clog2(DEPTH);

    state_t        r_state;
    logic [DW-1:0] r_depth;
    logic [AW-1:0] r_ret_addr;
    logic          r_ret_valid;
    logic          r_ovf_err;
    logic          r_unf_err;

    state_t        w_state_nxt;
    logic [DW-1:0] w_depth_nxt;
    logic [DW-1:0] w_top;
    logic          w_full;
    logic          w_empty;
    logic          w_we;
    logic [IW-1:0] w_waddr;
    logic [AW-1:0] w_rdata;
    logic          w_pop;
    logic          w_ovf_set;
    logic          w_unf_set;
    logic          w_err_clr;

    assign w_full  = (r_depth == DW'(DEPTH));
    assign w_empty = (r_depth == '0);
    assign w_top   = r_depth - DW'(1);

    always_comb begin
        w_state_nxt = r_state;
        w_depth_nxt = r_depth;
        w_we        = 1'b0;
        w_waddr     = r_depth[IW-1:0];
        w_pop       = 1'b0;
        w_ovf_set   = 1'b0;
        w_unf_set   = 1'b0;
        w_err_clr   = 1'b0;
        case (r_state)
            IDLE: begin
                // Swap: the popped top is read combinationally while the same
                // slot is overwritten at this edge, so depth stays put.
                if (call_req && ret_req && !w_empty) begin
                    w_pop   = 1'b1;
                    w_we    = 1'b1;
                    w_waddr = w_top[IW-1:0];
                end else if (call_req) begin
                    if (!w_full) begin
                        w_we        = 1'b1;
                        w_depth_nxt = r_depth + DW'(1);
                    end else begin
                        w_ovf_set   = 1'b1;
                        w_state_nxt = ERR;
                    end
                end else if (ret_req) begin
                    if (!w_empty) begin
                        w_pop       = 1'b1;
                        w_depth_nxt = w_top;
                    end else begin
                        w_unf_set   = 1'b1;
                        w_state_nxt = ERR;
                    end
                end
            end
            ERR: begin
                if (err_clr) begin
                    w_err_clr   = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_depth     <= '0;
            r_ret_addr  <= '0;
            r_ret_valid <= 1'b0;
            r_ovf_err   <= 1'b0;
            r_unf_err   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_depth     <= w_depth_nxt;
            r_ret_valid <= w_pop;
            if (w_pop) begin
                r_ret_addr <= w_rdata;
            end
            if (w_ovf_set) begin
                r_ovf_err <= 1'b1;
            end else if (w_err_clr) begin
                r_ovf_err <= 1'b0;
            end
            if (w_unf_set) begin
                r_unf_err <= 1'b1;
            end else if (w_err_clr) begin
                r_unf_err <= 1'b0;
            end
        end
    end

    lifo_mem #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .IW    (IW)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_we && !reset),
        .i_waddr (w_waddr),
        .i_wdata (push_addr),
        .i_raddr (w_top[IW-1:0]),
        .o_rdata (w_rdata)
    );

    assign ret_addr  = r_ret_addr;
    assign ret_valid = r_ret_valid;
    assign depth     = r_depth;
    assign full      = w_full;
    assign empty     = w_empty;
    assign ovf_err   = r_ovf_err;
    assign unf_err   = r_unf_err;
    assign dbg_state = r_state;

endmodule : call_stack_ctrl

// File: tb/tb_call_stack_ctrl.sv
// Directed bench for call_stack_ctrl: pops push expected addresses into a
// queue that a negedge monitor drains on every ret_valid strobe.
module tb_call_stack_ctrl;
    import call_stack_ctrl_pkg::*;

    localparam int DEPTH = 8;
    localparam int AW    = 10;
    localparam int DW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          call_req = 1'b0;
    logic          ret_req = 1'b0;
    logic [AW-1:0] push_addr = '0;
    logic          err_clr = 1'b0;
    logic [AW-1:0] ret_addr;
    logic          ret_valid;
    logic [DW-1:0] depth;
    logic          full;
    logic          empty;
    logic          ovf_err;
    logic          unf_err;
    state_t        dbg_state;

    int checks = 0;
    int errors = 0;
    logic [AW-1:0] exp_q[$];

    call_stack_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .call_req  (call_req),
        .ret_req   (ret_req),
        .push_addr (push_addr),
        .err_clr   (err_clr),
        .ret_addr  (ret_addr),
        .ret_valid (ret_valid),
        .depth     (depth),
        .full      (full),
        .empty     (empty),
        .ovf_err   (ovf_err),
        .unf_err   (unf_err),
        .dbg_state (dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not reach summary (act running, exp finished)");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: act=0x%0h exp=0x%0h", name, act, exp);
        end
    endtask

    // driver: inputs are applied at a negedge and held across one posedge
    task automatic step(input logic rst, input logic c, input logic r,
                        input logic [AW-1:0] a, input logic e);
        reset     = rst;
        call_req  = c;
        ret_req   = r;
        push_addr = a;
        err_clr   = e;
        @(negedge clk);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic push(input logic [AW-1:0] a);
        step(1'b0, 1'b1, 1'b0, a, 1'b0);
    endtask

    task automatic pop(input logic [AW-1:0] exp_addr);
        exp_q.push_back(exp_addr);
        step(1'b0, 1'b0, 1'b1, '0, 1'b0);
    endtask

    task automatic chk_flags(input string name, input int d, input int st,
                             input logic ovf, input logic unf);
        chk({name, "_depth"}, int'(depth), d);
        chk({name, "_state"}, int'(dbg_state), st);
        chk({name, "_ovf"}, int'(ovf_err), int'(ovf));
        chk({name, "_unf"}, int'(unf_err), int'(unf));
        chk({name, "_full"}, int'(full), int'(d == DEPTH));
        chk({name, "_empty"}, int'(empty), int'(d == 0));
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (ret_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_ret_valid: act ret_addr=0x%0h exp no strobe", ret_addr);
            end else begin
                automatic logic [AW-1:0] e = exp_q.pop_front();
                if (ret_addr !== e) begin
                    errors++;
                    $display("FAIL ret_addr: act=0x%0h exp=0x%0h", ret_addr, e);
                end
            end
        end
    end

    initial begin
        @(negedge clk);
        step(1'b1, 1'b0, 1'b0, '0, 1'b0);
        chk_flags("reset", 0, int'(IDLE), 1'b0, 1'b0);
        chk("reset_ret_addr", int'(ret_addr), 0);
        chk("reset_ret_valid", int'(ret_valid), 0);

        // LIFO order with back-to-back pushes and pops
        push(10'h011);
        push(10'h022);
        push(10'h033);
        chk_flags("push3", 3, int'(IDLE), 1'b0, 1'b0);
        pop(10'h033);
        pop(10'h022);
        pop(10'h011);
        chk_flags("pop3", 0, int'(IDLE), 1'b0, 1'b0);
        idle();
        chk("hold_ret_valid", int'(ret_valid), 0);
        chk("hold_ret_addr", int'(ret_addr), 'h011);

        // overflow freezes the stack until err_clr
        for (int i = 0; i < DEPTH; i++) push(AW'(10'h100 + i));
        chk_flags("fill", 8, int'(IDLE), 1'b0, 1'b0);
        push(10'h3FF);
        chk_flags("ovf", 8, int'(ERR), 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, '0, 1'b0);
        chk_flags("ovf_pop_ignored", 8, int'(ERR), 1'b1, 1'b0);
        chk("ovf_pop_no_strobe", int'(ret_valid), 0);
        step(1'b0, 1'b0, 1'b0, '0, 1'b1);
        chk_flags("ovf_clr", 8, int'(IDLE), 1'b0, 1'b0);
        for (int i = DEPTH - 1; i >= 0; i--) pop(AW'(10'h100 + i));
        chk_flags("drain", 0, int'(IDLE), 1'b0, 1'b0);

        // underflow
        step(1'b0, 1'b0, 1'b1, '0, 1'b0);
        chk_flags("unf", 0, int'(ERR), 1'b0, 1'b1);
        chk("unf_no_strobe", int'(ret_valid), 0);
        push(10'h055);
        chk_flags("unf_push_ignored", 0, int'(ERR), 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, '0, 1'b1);
        chk_flags("unf_clr", 0, int'(IDLE), 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 10'h0C3, 1'b1);
        chk_flags("clr_in_idle", 1, int'(IDLE), 1'b0, 1'b0);

        // swap at depth 2
        push(10'h0AA);
        chk_flags("pre_swap", 2, int'(IDLE), 1'b0, 1'b0);
        exp_q.push_back(10'h0AA);
        step(1'b0, 1'b1, 1'b1, 10'h155, 1'b0);
        chk_flags("swap", 2, int'(IDLE), 1'b0, 1'b0);
        pop(10'h155);
        pop(10'h0C3);

        // call+ret while empty acts as a plain push
        step(1'b0, 1'b1, 1'b1, 10'h2A5, 1'b0);
        chk_flags("both_empty", 1, int'(IDLE), 1'b0, 1'b0);
        pop(10'h2A5);

        // reset wins over a concurrent call mid-sequence
        for (int i = 0; i < 5; i++) push(AW'(10'h200 + i));
        chk_flags("depth5", 5, int'(IDLE), 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 10'h1EE, 1'b0);
        chk_flags("reset_call", 0, int'(IDLE), 1'b0, 1'b0);
        chk("reset_call_ret_valid", int'(ret_valid), 0);
        step(1'b0, 1'b0, 1'b1, '0, 1'b0);
        chk_flags("post_reset_unf", 0, int'(ERR), 1'b0, 1'b1);

        // reset wins over err_clr while in ERR
        step(1'b1, 1'b0, 1'b0, '0, 1'b1);
        chk_flags("reset_in_err", 0, int'(IDLE), 1'b0, 1'b0);
        chk("reset_in_err_ret_addr", int'(ret_addr), 0);

        idle();
        idle();
        chk("pending_pops", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_call_stack_ctrl

// File: doc/call_stack_ctrl.md
CALL_STACK_CTRL -- requirements
Module: call_stack_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 8, giving the number of return-address entries (power of two, 2..16).
REQ-002 SHALL have parameter AW, default 10, giving the return-address width in bits.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port call_req, input, 1, push request (subroutine call).
REQ-006 SHALL have port ret_req, input, 1, pop request (subroutine return).
REQ-007 SHALL have port push_addr, input, AW, return address to save, sampled with call_req.
REQ-008 SHALL have port err_clr, input, 1, clears the error state.
REQ-009 SHALL have port ret_addr, output, AW, popped return address.
REQ-010 SHALL have port ret_valid, output, 1, one-cycle strobe qualifying ret_addr.
REQ-011 SHALL have port depth, output, clog2(DEPTH)+1, current number of stored entries.
REQ-012 SHALL have ports full and empty, output, 1 each, combinational decodes of depth==DEPTH and depth==0.
REQ-013 SHALL have ports ovf_err and unf_err, output, 1 each, sticky overflow and underflow flags.

Function
REQ-014 SHALL implement FSM states IDLE and ERR; requests are accepted only in IDLE.
REQ-015 In IDLE, call_req=1, ret_req=0 and !full SHALL write push_addr at index depth and increment depth at the same edge.
REQ-016 In IDLE, ret_req=1, call_req=0 and !empty SHALL decrement depth and register entry depth-1 onto ret_addr with ret_valid=1 for exactly the following cycle.
REQ-017 In IDLE, call_req=1 and ret_req=1 with !empty SHALL output the top entry as in REQ-016, overwrite the top entry with push_addr and leave depth unchanged (swap).
REQ-018 call_req and ret_req both 1 with empty SHALL behave as a plain push (REQ-015); no underflow is flagged.
REQ-019 call_req alone while full SHALL perform no write, leave depth unchanged, set ovf_err and enter ERR.
REQ-020 ret_req alone while empty SHALL leave ret_valid=0, set unf_err and enter ERR.
REQ-021 In ERR, call_req and ret_req SHALL be ignored; memory, depth and ret_addr hold.
REQ-022 err_clr=1 in ERR SHALL clear ovf_err and unf_err and return to IDLE at the next edge, with depth preserved.
REQ-023 err_clr in IDLE SHALL have no effect.
REQ-024 ret_addr SHALL hold its last popped value while ret_valid=0.
REQ-025 Depth arithmetic SHALL saturate at 0 and DEPTH and never wrap.
REQ-026 Back-to-back requests on consecutive cycles SHALL each be accepted; the throughput is one operation per cycle.

Reset
REQ-027 At a rising edge with reset=1: state SHALL be IDLE, depth=0, ret_addr=0, ret_valid=0, ovf_err=0 and unf_err=0; memory contents are don't-care.
REQ-028 reset SHALL take priority over every request and over err_clr in the same cycle, including mid-sequence and in ERR.

Structure
REQ-029 A shared package SHALL hold the FSM state encoding (IDLE=0, ERR=1) and the default DEPTH/AW constants.
REQ-030 Storage SHALL be one sub-module, lifo_mem: a DEPTH x AW synchronous-write, combinational-read array with no reset.
REQ-031 The FSM, the depth counter and the output registers SHALL reside in call_stack_ctrl.

Verification
REQ-032 Reset, then push 0x011, 0x022, 0x033 on consecutive cycles, then three pops -> ret_addr 0x033, 0x022, 0x011 with ret_valid pulses; depth goes 3 -> 0; empty=1.
REQ-033 Push 8 entries, giving full=1; a ninth call_req with 0x3FF -> ovf_err=1, state ERR, depth=8, and a following pop is ignored; err_clr -> IDLE; the next pop returns the 8th value.
REQ-034 From empty, ret_req -> unf_err=1, ret_valid stays 0; the next call_req is ignored until err_clr.
REQ-035 depth=2 with top 0x0AA, then call_req and ret_req together with push_addr=0x155 -> ret_addr=0x0AA with ret_valid=1, depth=2; the next pop returns 0x155.
REQ-036 depth=5, then reset asserted together with call_req -> depth=0, all flags 0, ret_valid=0; a subsequent pop flags underflow.
